// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_pkg
// Description : Shared widths, register-zero index and requester encoding for
//               the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_arbiter_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned REG_ZERO = 31;

    typedef enum logic {
        REQ_WB0 = 1'b0,
        REQ_WB1 = 1'b1
    } req_e;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Pending-write bit per register with set/clear and three
//               combinational lookups (two read ports plus issue check).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_issue,
    output logic              o_hit_a,
    output logic              o_hit_b,
    output logic              o_hit_issue
);

    localparam int                c_NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO  = ADDR_W'(REG_ZERO);

    logic [c_NREGS-1:0] r_pend;

    // A fresh reservation outranks a stale clear of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (i_clr_en) begin
                r_pend[i_clr_addr] <= 1'b0;
            end
            if (i_set_en && (i_set_addr != c_ZERO)) begin
                r_pend[i_set_addr] <= 1'b1;
            end
        end
    end

    assign o_hit_a     = r_pend[i_addr_a]     && (i_addr_a != c_ZERO);
    assign o_hit_b     = r_pend[i_addr_b]     && (i_addr_b != c_ZERO);
    assign o_hit_issue = r_pend[i_addr_issue] && (i_addr_issue != c_ZERO);

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the register-file write port between a single-cycle
//               writeback (priority) and a multi-cycle unit with starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DATA_W       = regfile_wr_arbiter_pkg::DATA_W,
    parameter int ADDR_W       = regfile_wr_arbiter_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wb0Valid,
    input  logic [ADDR_W-1:0] Wb0Rd,
    input  logic [DATA_W-1:0] Wb0Data,
    output logic              Wb0Ready,
    input  logic              Wb1Valid,
    input  logic [ADDR_W-1:0] Wb1Rd,
    input  logic [DATA_W-1:0] Wb1Data,
    output logic              Wb1Ready,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic              IssueReady,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              HazA,
    output logic              HazB,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW
);

    import regfile_wr_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] c_ZERO  = ADDR_W'(REG_ZERO);
    localparam logic [3:0]        c_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]        r_starve_cnt;
    logic              r_regwr;
    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_busw;

    logic              w_at_limit;
    logic              w_grant0;
    logic              w_grant1;
    req_e              w_winner;
    logic [ADDR_W-1:0] w_win_rd;
    logic [DATA_W-1:0] w_win_data;
    logic              w_issue_hit;
    logic              w_issue_fire;

    assign w_at_limit = (r_starve_cnt == c_LIMIT);

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        w_winner = REQ_WB0;
        if (!Reset) begin
            if (w_at_limit && Wb1Valid) begin
                w_grant1 = 1'b1;
                w_winner = REQ_WB1;
            end else if (Wb0Valid) begin
                w_grant0 = 1'b1;
            end else if (Wb1Valid) begin
                w_grant1 = 1'b1;
                w_winner = REQ_WB1;
            end
        end
    end

    assign w_win_rd   = (w_winner == REQ_WB1) ? Wb1Rd   : Wb0Rd;
    assign w_win_data = (w_winner == REQ_WB1) ? Wb1Data : Wb0Data;

    assign Wb0Ready = w_grant0;
    assign Wb1Ready = w_grant1;

    // Counter only grows while WB1 is actually waiting; any release of Valid resets it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!Wb1Valid || w_grant1) begin
            r_starve_cnt <= 4'd0;
        end else if (!w_at_limit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Writes to register 31 complete the handshake but never reach the file.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_regwr <= 1'b0;
            r_rw    <= c_ZERO;
            r_busw  <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_regwr <= (w_win_rd != c_ZERO);
            r_rw    <= w_win_rd;
            r_busw  <= w_win_data;
        end else begin
            r_regwr <= 1'b0;
        end
    end

    assign RegWr = r_regwr;
    assign RW    = r_rw;
    assign BusW  = r_busw;

    assign IssueReady   = !Reset && !w_issue_hit;
    assign w_issue_fire = IssueValid && IssueReady;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (Clk),
        .rst          (Reset),
        .i_set_en     (w_issue_fire),
        .i_set_addr   (IssueRd),
        .i_clr_en     (w_grant1),
        .i_clr_addr   (Wb1Rd),
        .i_addr_a     (RA),
        .i_addr_b     (RB),
        .i_addr_issue (IssueRd),
        .o_hit_a      (HazA),
        .o_hit_b      (HazB),
        .o_hit_issue  (w_issue_hit)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Self-checking bench with a behavioural model and an output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int c_DW    = 64;
    localparam int c_AW    = 5;
    localparam int c_LIMIT = 4;

    typedef struct {
        logic            regwr;
        logic [c_AW-1:0] rw;
        logic [c_DW-1:0] busw;
    } wr_t;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Wb0Valid, Wb1Valid, IssueValid;
    logic [c_AW-1:0] Wb0Rd, Wb1Rd, IssueRd, RA, RB;
    logic [c_DW-1:0] Wb0Data, Wb1Data;
    logic            Wb0Ready, Wb1Ready, IssueReady, HazA, HazB, RegWr;
    logic [c_AW-1:0] RW;
    logic [c_DW-1:0] BusW;

    regfile_wr_arbiter #(
        .DATA_W       (c_DW),
        .ADDR_W       (c_AW),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Wb0Valid   (Wb0Valid),
        .Wb0Rd      (Wb0Rd),
        .Wb0Data    (Wb0Data),
        .Wb0Ready   (Wb0Ready),
        .Wb1Valid   (Wb1Valid),
        .Wb1Rd      (Wb1Rd),
        .Wb1Data    (Wb1Data),
        .Wb1Ready   (Wb1Ready),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .IssueReady (IssueReady),
        .RA         (RA),
        .RB         (RB),
        .HazA       (HazA),
        .HazB       (HazB),
        .RegWr      (RegWr),
        .RW         (RW),
        .BusW       (BusW)
    );

    always #5 Clk = ~Clk;

    int        n_vec = 0;
    int        n_err = 0;
    wr_t       exp_q[$];
    int        m_cnt;
    logic [31:0] m_pend;
    logic [c_AW-1:0] m_rw;
    logic [c_DW-1:0] m_busw;
    logic      s_w1rdy;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: check combinational outputs at negedge, check registered outputs after posedge.
    task automatic step();
        logic g0, g1, ird;
        wr_t  w, got;
        @(negedge Clk);
        g1  = !Reset && Wb1Valid && ((m_cnt == c_LIMIT) || !Wb0Valid);
        g0  = !Reset && Wb0Valid && !g1;
        ird = !Reset && !m_pend[IssueRd];
        chk("wb0_ready", 64'(Wb0Ready), 64'(g0));
        chk("wb1_ready", 64'(Wb1Ready), 64'(g1));
        chk("issue_ready", 64'(IssueReady), 64'(ird));
        chk("haz_a", 64'(HazA), 64'(m_pend[RA]));
        chk("haz_b", 64'(HazB), 64'(m_pend[RB]));
        s_w1rdy = Wb1Ready;
        if (Reset) begin
            m_cnt  = 0;
            m_pend = '0;
            m_rw   = 5'd31;
            m_busw = '0;
            w = '{1'b0, m_rw, m_busw};
        end else begin
            if (g0) begin
                m_rw = Wb0Rd; m_busw = Wb0Data;
                w = '{(Wb0Rd != 5'd31), m_rw, m_busw};
            end else if (g1) begin
                m_rw = Wb1Rd; m_busw = Wb1Data;
                w = '{(Wb1Rd != 5'd31), m_rw, m_busw};
            end else begin
                w = '{1'b0, m_rw, m_busw};
            end
            if (!Wb1Valid || g1) m_cnt = 0;
            else if (m_cnt < c_LIMIT) m_cnt++;
            if (g1) m_pend[Wb1Rd] = 1'b0;
            if (IssueValid && ird && IssueRd != 5'd31) m_pend[IssueRd] = 1'b1;
        end
        exp_q.push_back(w);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 64'd1, 64'd0);
        end else begin
            got = exp_q.pop_front();
            chk("regwr", 64'(RegWr), 64'(got.regwr));
            chk("rw", 64'(RW), 64'(got.rw));
            chk("busw", BusW, got.busw);
        end
    endtask

    task automatic idle();
        Wb0Valid = 0; Wb1Valid = 0; IssueValid = 0;
        Wb0Rd = 0; Wb1Rd = 0; IssueRd = 0; RA = 0; RB = 0;
        Wb0Data = 0; Wb1Data = 0;
    endtask

    initial begin
        idle();
        Reset = 1; m_cnt = 0; m_pend = '0; m_rw = 5'd31; m_busw = '0; s_w1rdy = 0;
        @(posedge Clk); #1;

        // Reset held with both requesters asking
        Wb0Valid = 1; Wb1Valid = 1; Wb0Rd = 3; Wb1Rd = 4;
        repeat (2) step();
        Reset = 0; idle();
        step();

        // Plain WB0 write
        Wb0Valid = 1; Wb0Rd = 5; Wb0Data = 64'hDEAD;
        step();
        idle();
        step();
        chk("wb0_regwr_value", 64'(RW), 64'd5);
        step();

        // Starvation guard: WB0 wins four times, then WB1
        for (int i = 0; i < 10; i++) begin
            Wb0Valid = 1; Wb0Rd = 5'(i + 1); Wb0Data = 64'(32'h1000 + i);
            Wb1Valid = 1; Wb1Rd = 5'(i + 12); Wb1Data = 64'(32'h2000 + i);
            step();
            chk("starve_pattern", 64'(s_w1rdy), 64'((i % 5) == 4));
        end
        idle();
        step();

        // Scoreboard reserve, hazard, WAW block, clear
        IssueValid = 1; IssueRd = 7;
        step();
        RA = 7;
        step();
        IssueValid = 0; Wb1Valid = 1; Wb1Rd = 7; Wb1Data = 64'h77;
        step();
        Wb1Valid = 0; IssueValid = 1; IssueRd = 7; RA = 7; RB = 7;
        step();
        IssueValid = 0;
        step();
        Wb1Valid = 1; Wb1Rd = 7; Wb1Data = 64'h78;
        step();
        idle();
        step();

        // Register 31 handling
        Wb1Valid = 1; Wb1Rd = 31; Wb1Data = 64'h1234;
        step();
        idle();
        step();
        IssueValid = 1; IssueRd = 31;
        step();
        IssueValid = 0; RA = 31; RB = 31;
        step();

        // Reset while WB1 waits at counter 3 with a pending reservation
        idle();
        IssueValid = 1; IssueRd = 9;
        step();
        IssueValid = 0; RA = 9;
        Wb0Valid = 1; Wb0Rd = 2; Wb0Data = 64'hAA;
        Wb1Valid = 1; Wb1Rd = 9; Wb1Data = 64'hBB;
        repeat (3) step();
        Reset = 1;
        step();
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_reset_pattern", 64'(s_w1rdy), 64'(i == 4));
        end
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            Wb0Valid   = 1'($urandom_range(0, 1));
            Wb1Valid   = 1'($urandom_range(0, 1));
            IssueValid = 1'($urandom_range(0, 1));
            Wb0Rd      = 5'($urandom_range(0, 31));
            Wb1Rd      = 5'($urandom_range(0, 31));
            IssueRd    = 5'($urandom_range(0, 31));
            RA         = 5'($urandom_range(0, 31));
            RB         = 5'($urandom_range(0, 31));
            Wb0Data    = {32'($urandom), 32'($urandom)};
            Wb1Data    = {32'($urandom), 32'($urandom)};
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
